mac_pe_sched: RTL and testbench

MAC_PE_SCHED -- requirements
Module: mac_pe_sched

---
 rtl/mac_pe_sched_pkg.sv | 19 +
 rtl/mac_pe_sched_arb.sv | 57 +++++
 rtl/mac_pe_sched.sv | 149 ++++++++++++++
 tb/tb_mac_pe_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pe_sched_pkg.sv
// mac_pe_sched_pkg: shared definitions for the PE row scheduler.
//   state_t        - scheduler FSM states
//   ROW_W_DEF      - default width of row count / row index
//   ROW_STRIDE_DEF - default byte distance between consecutive row bases
//   ADDR_W         - width of a PE base address
package mac_pe_sched_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned ROW_W_DEF      = 8;
  localparam int unsigned ROW_STRIDE_DEF = 128;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_FINISH   = 2'd3
  } state_t;

endpackage

// File: rtl/mac_pe_sched_arb.sv
// rr_arbiter: registered round-robin arbiter for one shared BRAM port.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   req  - per-requester request, NUM_PE bits
//   gnt  - registered one-hot-or-zero grant, NUM_PE bits
// A grant is held while its request stays high. When that request drops,
// the grant clears on the next edge and a fresh winner is registered one
// edge later, so there is always one zero-grant cycle between owners.
module rr_arbiter #(
  parameter int unsigned NUM_PE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PE-1:0] req,
  output logic [NUM_PE-1:0] gnt
);

  localparam int unsigned PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [PTR_W-1:0]  ptr_q;
  logic [NUM_PE-1:0] gnt_q;
  logic [NUM_PE-1:0] pick_oh;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  int unsigned       idx;

  // Search starts one above the last granted index and wraps.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned off = 1; off <= NUM_PE; off++) begin
      idx = (32'(ptr_q) + off) % NUM_PE;
      if (!pick_vld && req[idx]) begin
        pick_oh[idx] = 1'b1;
        pick_idx     = PTR_W'(idx);
        pick_vld     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= PTR_W'(NUM_PE - 1);
    end else if (gnt_q != '0) begin
      if ((gnt_q & req) == '0) gnt_q <= '0;
    end else if (pick_vld) begin
      gnt_q <= pick_oh;
      ptr_q <= pick_idx;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/mac_pe_sched.sv
// mac_pe_sched: hands the rows of a job out to NUM_PE processing-element
// controllers and arbitrates their shared BRAM port.
//   aclk, areset - clock, asynchronous active-high reset
//   start        - job request, sampled only in IDLE
//   num_rows     - rows in the job, sampled with start
//   busy         - high while rows are being dispatched or drained
//   done         - one-cycle completion pulse
//   pe_start     - one-cycle start pulse per PE
//   pe_done      - one-cycle completion pulse per PE
//   pe_base      - per-PE row base byte address, ADDR_W bits each
//   pe_req       - per-PE request for the shared BRAM port
//   pe_gnt       - one-hot-or-zero BRAM port grant
module mac_pe_sched
  import mac_pe_sched_pkg::*;
#(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned ROW_W      = ROW_W_DEF,
  parameter int unsigned ROW_STRIDE = ROW_STRIDE_DEF
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  input  logic [ROW_W-1:0]         num_rows,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_PE-1:0]        pe_start,
  input  logic [NUM_PE-1:0]        pe_done,
  output logic [NUM_PE*ADDR_W-1:0] pe_base,
  input  logic [NUM_PE-1:0]        pe_req,
  output logic [NUM_PE-1:0]        pe_gnt
);

  // One spare bit so a maximal row count never wraps.
  localparam int unsigned CNT_W = ROW_W + 1;

  state_t                   state_q, state_d;
  logic [ROW_W-1:0]         rows_q;
  logic [CNT_W-1:0]         issued_q;
  logic [CNT_W-1:0]         completed_q;
  logic [NUM_PE-1:0]        idle_q;
  logic [NUM_PE-1:0]        pe_start_q;
  logic [NUM_PE*ADDR_W-1:0] base_q;
  logic                     zero_done_q;

  logic                     accept;
  logic                     job_go;
  logic                     zero_go;
  logic                     dispatch_en;
  logic [NUM_PE-1:0]        free_oh;
  logic                     found;
  logic [NUM_PE-1:0]        issue_fire;
  logic [NUM_PE-1:0]        done_acc;
  logic [ADDR_W-1:0]        issue_addr;

  assign accept  = (state_q == S_IDLE) && start;
  assign job_go  = accept && (num_rows != '0);
  assign zero_go = accept && (num_rows == '0);

  // pe_done on an already idle PE carries no information and is dropped.
  assign done_acc   = pe_done & ~idle_q;
  assign issue_addr = ADDR_W'(issued_q) * ADDR_W'(ROW_STRIDE);

  // Eligibility uses the registered idle bits only, so a PE finishing this
  // cycle is not restarted until the next one.
  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (!found && idle_q[i]) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign issue_fire = dispatch_en ? free_oh : '0;

  // FSM: state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (job_go) state_d = S_DISPATCH;
      S_DISPATCH: if (issued_q == {1'b0, rows_q}) state_d = S_DRAIN;
      S_DRAIN:    if ((&idle_q) && (completed_q == issued_q)) state_d = S_FINISH;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy        = 1'b0;
    dispatch_en = 1'b0;
    done        = zero_done_q;
    case (state_q)
      S_DISPATCH: begin
        busy        = 1'b1;
        dispatch_en = (issued_q != {1'b0, rows_q});
      end
      S_DRAIN:  busy = 1'b1;
      S_FINISH: done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rows_q      <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      idle_q      <= '1;
      pe_start_q  <= '0;
      base_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      pe_start_q  <= issue_fire;
      zero_done_q <= zero_go;
      idle_q      <= (idle_q | pe_done) & ~issue_fire;
      if (job_go) begin
        rows_q      <= num_rows;
        issued_q    <= '0;
        completed_q <= '0;
      end else begin
        if (issue_fire != '0) issued_q <= issued_q + CNT_W'(1);
        completed_q <= completed_q + CNT_W'($countones(done_acc));
      end
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (issue_fire[i]) base_q[i*ADDR_W +: ADDR_W] <= issue_addr;
      end
    end
  end

  assign pe_start = pe_start_q;
  assign pe_base  = base_q;

  rr_arbiter #(.NUM_PE(NUM_PE)) u_arb (
    .clk (aclk),
    .rst (areset),
    .req (pe_req),
    .gnt (pe_gnt)
  );

endmodule

// File: tb/tb_mac_pe_sched.sv
// tb_mac_pe_sched: scoreboard bench for mac_pe_sched (4-PE and 1-PE builds).
module tb_mac_pe_sched;

  localparam int NPE    = 4;
  localparam int STRIDE = 128;

  logic             aclk = 1'b0;
  logic             areset;
  logic             start, start1;
  logic [7:0]       num_rows, num_rows1;
  logic             busy, done, busy1, done1;
  logic [NPE-1:0]   pe_start, pe_done, pe_req, pe_gnt;
  logic [NPE*32-1:0] pe_base;
  logic [0:0]       pe_start1, pe_done1, pe_req1, pe_gnt1;
  logic [31:0]      pe_base1;

  mac_pe_sched #(.NUM_PE(4), .ROW_W(8), .ROW_STRIDE(128)) dut (
    .aclk(aclk), .areset(areset), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .pe_start(pe_start), .pe_done(pe_done),
    .pe_base(pe_base), .pe_req(pe_req), .pe_gnt(pe_gnt)
  );

  mac_pe_sched #(.NUM_PE(1), .ROW_W(8), .ROW_STRIDE(128)) dut1 (
    .aclk(aclk), .areset(areset), .start(start1), .num_rows(num_rows1),
    .busy(busy1), .done(done1), .pe_start(pe_start1), .pe_done(pe_done1),
    .pe_base(pe_base1), .pe_req(pe_req1), .pe_gnt(pe_gnt1)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  typedef struct {
    int          idx;
    logic [31:0] base;
  } exp_t;

  exp_t        sq[$];
  logic [31:0] q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0, start_cnt = 0, done1_cnt = 0, start1_cnt = 0;
  logic job_active = 1'b0;
  int job_cyc = 0;
  int lat[NPE];
  int tmr[NPE];
  int tmr1;
  int last_done_cyc[NPE];
  int start_gap[NPE];
  logic [31:0] last_base[NPE];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // PE responders plus start/done/busy monitor, all at the falling edge.
  initial begin
    int   idx;
    exp_t e;
    pe_done  = '0;
    pe_done1 = '0;
    tmr1     = 0;
    for (int i = 0; i < NPE; i++) begin
      tmr[i] = 0; last_done_cyc[i] = -1000; start_gap[i] = 0;
    end
    forever begin
      @(negedge aclk);
      for (int i = 0; i < NPE; i++) begin
        pe_done[i] = 1'b0;
        if (areset) tmr[i] = 0;
        else if (tmr[i] > 0) begin
          tmr[i]--;
          if (tmr[i] == 0) begin
            pe_done[i] = 1'b1;
            last_done_cyc[i] = cyc;
          end
        end
      end
      pe_done1 = 1'b0;
      if (areset) tmr1 = 0;
      else if (tmr1 > 0) begin
        tmr1--;
        if (tmr1 == 0) pe_done1 = 1'b1;
      end
      if (!areset) begin
        if (done)  done_cnt++;
        if (done1) done1_cnt++;
        if (job_active && cyc > job_cyc) begin
          if (done) begin
            check("busy_low_at_done", busy, 0);
            job_active = 1'b0;
          end else begin
            check("busy_mid_job", busy, 1);
          end
        end
        if (pe_start != '0) begin
          check("pe_start_onehot", $countones(pe_start), 1);
          idx = 0;
          for (int i = NPE - 1; i >= 0; i--) if (pe_start[i]) idx = i;
          start_cnt++;
          start_gap[idx] = cyc - last_done_cyc[idx];
          if (sq.size() == 0) begin
            check("extra_pe_start", pe_start, 0);
          end else begin
            e = sq.pop_front();
            check("pe_start_idx", idx, e.idx);
            check("pe_base", pe_base[idx*32 +: 32], e.base);
            last_base[idx] = e.base;
          end
          tmr[idx] = lat[idx];
        end
        if (pe_start1[0]) begin
          start1_cnt++;
          if (q1.size() == 0) check("extra_pe_start_1pe", pe_start1, 0);
          else                check("pe_base_1pe", pe_base1, q1.pop_front());
          tmr1 = 2;
        end
      end
    end
  end

  task automatic push_rows(input int rows);
    for (int k = 0; k < rows; k++) sq.push_back('{k % NPE, 32'(k * STRIDE)});
  endtask

  task automatic start_job(input int rows);
    @(negedge aclk);
    done_cnt   = 0;
    start_cnt  = 0;
    start      = 1'b1;
    num_rows   = 8'(rows);
    job_cyc    = cyc;
    job_active = (rows != 0);
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (job_active && c < budget) begin
      @(negedge aclk);
      c++;
    end
    check("job_completes", job_active, 0);
    repeat (4) @(negedge aclk);
  endtask

  task automatic end_checks(input int rows);
    check("done_pulses", done_cnt, 1);
    check("start_count", start_cnt, rows);
    check("scoreboard_empty", sq.size(), 0);
    check("busy_after_job", busy, 0);
  endtask

  task automatic arb_test();
    int   exp_q[$];
    int   held, zero_run, idx, ngrant;
    logic [NPE-1:0] prev;
    exp_q = '{0, 1, 2, 3, 0};
    held = 0; zero_run = 0; idx = 0; ngrant = 0; prev = '0;
    @(negedge aclk);
    pe_req = 4'hF;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge aclk);
      pe_req = 4'hF;
      check("gnt_onehot", ($countones(pe_gnt) <= 1), 1);
      if (pe_gnt == '0) begin
        if (prev != '0) check("gnt_hold_cycles", held, 3);
        zero_run++;
      end else begin
        if (prev == '0) begin
          for (int i = NPE - 1; i >= 0; i--) if (pe_gnt[i]) idx = i;
          check("gnt_order", idx, exp_q.pop_front());
          if (ngrant > 0) check("gnt_gap", zero_run, 1);
          ngrant++;
          held = 0;
          zero_run = 0;
        end
        held++;
        if (held == 3) pe_req[idx] = 1'b0;
      end
      prev = pe_gnt;
    end
    check("arb_all_grants", exp_q.size(), 0);
    pe_req = '0;
    repeat (4) @(negedge aclk);
    check("gnt_released", pe_gnt, 0);
  endtask

  initial begin
    int c, dc;
    areset = 1'b1; start = 1'b0; num_rows = '0; start1 = 1'b0; num_rows1 = '0;
    pe_req = '0; pe_req1 = '0;
    for (int i = 0; i < NPE; i++) begin lat[i] = 20; last_base[i] = '0; end
    repeat (3) @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pe_start", pe_start, 0);
    check("rst_pe_gnt", pe_gnt, 0);
    for (int i = 0; i < NPE; i++) check("rst_pe_base", pe_base[i*32 +: 32], 0);
    areset = 1'b0;

    arb_test();

    // Six rows over four PEs, with a stray start mid-job.
    push_rows(6);
    start_job(6);
    repeat (10) @(negedge aclk);
    start = 1'b1; num_rows = 8'd2;
    @(negedge aclk);
    start = 1'b0;
    wait_done(200);
    end_checks(6);
    for (int i = 0; i < NPE; i++) check("pe_base_hold", pe_base[i*32 +: 32], last_base[i]);

    // Zero-row job.
    start_job(0);
    check("zero_rows_done", done, 1);
    check("zero_rows_busy", busy, 0);
    @(negedge aclk);
    check("zero_rows_done_once", done, 0);
    check("zero_rows_busy2", busy, 0);
    repeat (3) @(negedge aclk);
    check("zero_rows_no_start", start_cnt, 0);
    check("zero_rows_done_cnt", done_cnt, 1);

    // PE2 finishes while the scheduler is waiting to dispatch row 4.
    lat = '{40, 40, 5, 40};
    push_rows(4);
    sq.push_back('{2, 32'(4 * STRIDE)});
    start_job(5);
    wait_done(300);
    end_checks(5);
    check("pe2_restart_gap", start_gap[2], 2);

    // Reset while draining with two PEs still busy.
    lat = '{20, 20, 20, 20};
    push_rows(6);
    start_job(6);
    pe_req = 4'b0001;
    c = 0;
    while (start_cnt < 6 && c < 100) begin @(negedge aclk); c++; end
    check("reset_test_starts", start_cnt, 6);
    repeat (8) @(negedge aclk);
    check("busy_in_drain", busy, 1);
    check("gnt_before_reset", pe_gnt, 1);
    dc = done_cnt;
    job_active = 1'b0;
    #2 areset = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_pe_start", pe_start, 0);
    check("async_rst_pe_gnt", pe_gnt, 0);
    for (int i = 0; i < NPE; i++) begin
      check("async_rst_pe_base", pe_base[i*32 +: 32], 0);
      last_base[i] = '0;
    end
    @(negedge aclk);
    pe_req = '0;
    @(negedge aclk);
    areset = 1'b0;
    repeat (5) @(negedge aclk);
    check("no_done_after_reset", done_cnt, dc);
    check("busy_after_reset", busy, 0);
    push_rows(3);
    start_job(3);
    wait_done(200);
    end_checks(3);

    // Single PE, maximal row count.
    for (int k = 0; k < 255; k++) q1.push_back(32'(k * STRIDE));
    @(negedge aclk);
    done1_cnt = 0; start1_cnt = 0;
    start1 = 1'b1; num_rows1 = 8'd255;
    @(negedge aclk);
    start1 = 1'b0;
    check("one_pe_busy", busy1, 1);
    c = 0;
    while (done1_cnt == 0 && c < 1500) begin @(negedge aclk); c++; end
    repeat (4) @(negedge aclk);
    check("one_pe_done_cnt", done1_cnt, 1);
    check("one_pe_starts", start1_cnt, 255);
    check("one_pe_last_base", pe_base1, 32'd32512);
    check("one_pe_queue", q1.size(), 0);
    check("one_pe_busy_end", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
